// File: rtl/pipe_fetch_pkg.sv
// rtl/pipe_fetch_pkg.sv - shared fetch-stage types and constants
package pipe_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int NOP_INS     = 0;
  localparam int DEF_PC_STEP = 4;

endpackage

// File: rtl/pipe_fetch_ifid_reg.sv
// rtl/pipe_fetch_ifid_reg.sv - IF/ID pipeline register with load and flush clear
module ifid_reg
  import pipe_fetch_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int INS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [INS_W-1:0] ins_in,
  input  logic [PC_W-1:0]  pc4_in,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  pc4,
  output logic             valid
);

  // Clear wins over load so a flush always leaves a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ins   <= INS_W'(NOP_INS);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (clear) begin
      ins   <= INS_W'(NOP_INS);
      pc4   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      ins   <= ins_in;
      pc4   <= pc4_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pipe_fetch.sv
// rtl/pipe_fetch.sv - instruction fetch FSM with stall hold buffer and flush drain
module pipe_fetch
  import pipe_fetch_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INS_W   = 32,
  parameter int PC_STEP = DEF_PC_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  i_pc,
  input  logic             wpcir,
  input  logic             flush,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_data,
  output logic [INS_W-1:0] o_ins,
  output logic [PC_W-1:0]  o_pc4,
  output logic             o_valid,
  output logic             pc_adv
);

  fetch_state_e     state_q, state_d;
  logic             req_d;
  logic [PC_W-1:0]  addr_d;
  logic [INS_W-1:0] hold_ins;
  logic [PC_W-1:0]  hold_pc4;
  logic             hold_ld, hold_clr;
  logic             ifid_ld, ifid_clr, ifid_from_hold;
  logic [PC_W-1:0]  addr_pc4;
  logic [INS_W-1:0] ifid_ins;
  logic [PC_W-1:0]  ifid_pc4;

  assign addr_pc4 = imem_addr + PC_W'(PC_STEP);
  assign ifid_ins = ifid_from_hold ? hold_ins : imem_data;
  assign ifid_pc4 = ifid_from_hold ? hold_pc4 : addr_pc4;

  always_comb begin
    state_d        = state_q;
    req_d          = imem_req;
    addr_d         = imem_addr;
    hold_ld        = 1'b0;
    hold_clr       = 1'b0;
    ifid_ld        = 1'b0;
    ifid_clr       = 1'b0;
    ifid_from_hold = 1'b0;
    pc_adv         = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          ifid_clr = 1'b1;
        end else begin
          addr_d  = i_pc;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (flush) begin
          ifid_clr = 1'b1;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          req_d = 1'b0;
          if (wpcir) begin
            ifid_ld = 1'b1;
            pc_adv  = 1'b1;
            state_d = IDLE;
          end else begin
            hold_ld = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (flush) begin
          ifid_clr = 1'b1;
          hold_clr = 1'b1;
          state_d  = IDLE;
        end else if (wpcir) begin
          ifid_ld        = 1'b1;
          ifid_from_hold = 1'b1;
          pc_adv         = 1'b1;
          state_d        = IDLE;
        end
      end
      DRAIN: begin
        // The squashed word is still owed by memory; wait it out before redirecting.
        if (flush) begin
          ifid_clr = 1'b1;
        end else if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      hold_ins  <= '0;
      hold_pc4  <= '0;
    end else begin
      state_q   <= state_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
      if (hold_clr) begin
        hold_ins <= '0;
        hold_pc4 <= '0;
      end else if (hold_ld) begin
        hold_ins <= imem_data;
        hold_pc4 <= addr_pc4;
      end
    end
  end

  ifid_reg #(
    .PC_W  (PC_W),
    .INS_W (INS_W)
  ) u_ifid (
    .clk    (clk),
    .rst    (rst),
    .load   (ifid_ld),
    .clear  (ifid_clr),
    .ins_in (ifid_ins),
    .pc4_in (ifid_pc4),
    .ins    (o_ins),
    .pc4    (o_pc4),
    .valid  (o_valid)
  );

endmodule
